// File: rtl/z80_bus_resp.sv
// Z80 bus responder: memory with programmable wait states, access counters and a sticky error flag.
// Define Z80_BUS_RESP_IO_EN to add a 16-entry I/O register file decoded on IORQ_n cycles.
module z80_bus_resp #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              CLK,
  input  logic              RESET_n,
  input  logic              M1_n,
  input  logic              MREQ_n,
  input  logic              IORQ_n,
  input  logic              RD_n,
  input  logic              WR_n,
  input  logic              RFSH_n,
  input  logic [ADDR_W-1:0] A,
  inout  wire  [DATA_W-1:0] D,
  output logic              WAIT_n,
  output logic [15:0]       RD_CNT,
  output logic [15:0]       WR_CNT,
  output logic              ERR
);

  localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned LatW     = (IdxW > 4) ? IdxW : 4;
  localparam int unsigned WaitLoad = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {StIdle, StWait, StDrive, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [LatW-1:0]   r_idx, w_idx_d;
  logic              r_rd, w_rd_d;
  logic              r_io, w_io_d;
  logic [3:0]        r_wcnt, w_wcnt_d;
  logic [15:0]       r_rd_cnt, w_rd_cnt_d;
  logic [15:0]       r_wr_cnt, w_wr_cnt_d;
  logic              r_err, w_err_d;
  logic              w_we;
  logic              w_mem_we;
  logic              w_mem_sel, w_io_sel;
  logic              w_one_dir, w_both;
  logic              w_held, w_bus_idle;
  logic              w_drive;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_unused_bits;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  assign w_mem_sel = !MREQ_n && RFSH_n;
  assign w_one_dir = RD_n ^ WR_n;
  assign w_both    = !RD_n && !WR_n;

`ifdef Z80_BUS_RESP_IO_EN
  logic [DATA_W-1:0] r_io_regs [16];
  logic              w_io_we;

  // Interrupt acknowledge (M1_n low) never qualifies as an I/O access.
  assign w_io_sel   = !IORQ_n && M1_n;
  assign w_bus_idle = MREQ_n && IORQ_n;
  assign w_held     = (r_io ? !IORQ_n : !MREQ_n) && (r_rd ? !RD_n : !WR_n);
  assign w_io_we    = w_we && r_io;
  assign w_rd_data  = r_io ? r_io_regs[r_idx[3:0]] : r_mem[r_idx[IdxW-1:0]];

  always_ff @(posedge CLK) begin
    if (w_io_we) r_io_regs[r_idx[3:0]] <= D;
  end
`else
  assign w_io_sel   = 1'b0;
  assign w_bus_idle = MREQ_n;
  assign w_held     = !MREQ_n && (r_rd ? !RD_n : !WR_n);
  assign w_rd_data  = r_mem[r_idx[IdxW-1:0]];
`endif

  assign w_unused_bits = ^{A, IORQ_n, M1_n, r_io, r_idx};
  assign w_mem_we      = w_we && !r_io;

  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_rd_d     = r_rd;
    w_io_d     = r_io;
    w_wcnt_d   = r_wcnt;
    w_rd_cnt_d = r_rd_cnt;
    w_wr_cnt_d = r_wr_cnt;
    w_err_d    = r_err;
    w_we       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_mem_sel || w_io_sel) begin
          if (w_both) begin
            w_err_d   = 1'b1;
            w_state_d = StDone;
          end else if (w_one_dir) begin
            w_idx_d   = A[LatW-1:0];
            w_rd_d    = !RD_n;
            w_io_d    = !w_mem_sel;
            w_wcnt_d  = 4'(WaitLoad);
            w_state_d = (WAIT_CYCLES > 0) ? StWait : StDrive;
          end
        end
      end
      StWait: begin
        // Early strobe release aborts: no write, no count.
        if (!w_held) begin
          w_err_d   = 1'b1;
          w_state_d = StDone;
        end else if (r_wcnt == 4'd0) begin
          w_state_d = StDrive;
        end else begin
          w_wcnt_d = r_wcnt - 4'd1;
        end
      end
      StDrive: begin
        if (r_rd) begin
          if (!w_held) begin
            w_rd_cnt_d = (r_rd_cnt == 16'hFFFF) ? r_rd_cnt : r_rd_cnt + 16'd1;
            w_state_d  = StDone;
          end
        end else begin
          w_we       = 1'b1;
          w_wr_cnt_d = (r_wr_cnt == 16'hFFFF) ? r_wr_cnt : r_wr_cnt + 16'd1;
          w_state_d  = StDone;
        end
      end
      StDone: begin
        if (w_bus_idle) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_rd     <= 1'b0;
      r_io     <= 1'b0;
      r_wcnt   <= 4'd0;
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_rd     <= w_rd_d;
      r_io     <= w_io_d;
      r_wcnt   <= w_wcnt_d;
      r_rd_cnt <= w_rd_cnt_d;
      r_wr_cnt <= w_wr_cnt_d;
      r_err    <= w_err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[r_idx[IdxW-1:0]] <= D;
  end

  assign w_drive = (r_state == StDrive) && r_rd;
  assign D       = w_drive ? w_rd_data : {DATA_W{1'bz}};
  assign WAIT_n  = (r_state != StWait);
  assign RD_CNT  = r_rd_cnt;
  assign WR_CNT  = r_wr_cnt;
  assign ERR     = r_err;

endmodule
